pwm_multi: RTL

Parametrised multi-channel PWM generator; successor to the single-channel 8-bit `pwm` block. It has a shared prescaler and a shared period counter. Per-channel duty cycles are written through a simple write port into shadow registers, and the shadow values go live only at a period boundary so the outputs never glitch. The block sits between the control-law logic, which writes the duties, and the motor/LED drive pins.

---
 rtl/pwm_multi_pkg.sv | 22 ++
 rtl/pwm_prescaler.sv | 22 ++
 rtl/pwm_multi.sv | 106 ++++++++++
 3 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared defaults, counter direction encoding and the write-index width helper
// for the pwm_multi family.
package pwm_multi_pkg;

   localparam int PWM_DEF_WIDTH    = 8;
   localparam int PWM_DEF_CHANNELS = 4;
   localparam int PWM_DEF_DIV_W    = 8;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // ceil(log2(n)), never below 1 so a single-channel build still has a wr_ch bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every div+1 clocks, divisor used live.
module pwm_prescaler
   import pwm_multi_pkg::*;
#(
   parameter int DIV_W = PWM_DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] pre_cnt;

   assign tick = (pre_cnt == div);

   always_ff @(posedge clk) begin
      if (rst || tick) pre_cnt <= '0;
      else             pre_cnt <= pre_cnt + DIV_W'(1);
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared prescaler/period counter and boundary-synchronous
// duty/top reload. Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting.
module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter  int WIDTH    = PWM_DEF_WIDTH,
   parameter  int CHANNELS = PWM_DEF_CHANNELS,
   parameter  int DIV_W    = PWM_DEF_DIV_W,
   localparam int CH_W     = clog2_min1(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIV_W-1:0]    div,
   input  logic [WIDTH-1:0]    top,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_duty,
   output logic [CHANNELS-1:0] PWM,
   output logic                period_start
);

   logic             tick;
   logic             boundary;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] top_act;

   pwm_prescaler #(.DIV_W(DIV_W)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .div  (div),
      .tick (tick)
   );

`ifdef PWM_CENTER_ALIGN_EN
   dir_e dir;
   dir_e dir_nxt;

   assign boundary = tick && (((cnt == '0) && (dir == DIR_DOWN)) || (top_act == '0));

   // Boundary restarts the up-slope at 1 so cnt==0 appears once per period.
   always_comb begin
      cnt_nxt = cnt;
      dir_nxt = dir;
      if (boundary) begin
         dir_nxt = DIR_UP;
         cnt_nxt = (top == '0) ? '0 : WIDTH'(1);
      end else if (dir == DIR_UP) begin
         if (cnt >= top_act) begin
            dir_nxt = DIR_DOWN;
            cnt_nxt = cnt - WIDTH'(1);
         end else begin
            cnt_nxt = cnt + WIDTH'(1);
         end
      end else begin
         cnt_nxt = cnt - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       dir <= DIR_UP;
      else if (tick) dir <= dir_nxt;
   end
`else
   assign boundary = tick && (cnt == top_act);

   always_comb begin
      cnt_nxt = cnt + WIDTH'(1);
      if (cnt == top_act) cnt_nxt = '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         top_act      <= '1;
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
         if (boundary) top_act <= top;
         if (tick)     cnt     <= cnt_nxt;
      end
   end

   // An out-of-range wr_ch matches no channel index, so the write is dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] shadow;
      logic [WIDTH-1:0] duty_act;
      logic             pwm_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            shadow   <= '0;
            duty_act <= '0;
            pwm_q    <= 1'b0;
         end else begin
            if (boundary)                         duty_act <= shadow;
            if (wr_en && (wr_ch == CH_W'(i)))     shadow   <= wr_duty;
            pwm_q <= (cnt < duty_act);
         end
      end

      assign PWM[i] = pwm_q;
   end

endmodule
